// File: rtl/getir_birimi_pkg.sv
// Shared types and constants for the GETIR fetch stage: FSM states, opcodes, default widths/reset PC.
package getir_birimi_pkg;

  localparam int unsigned ADRES_BIT_VARSAYILAN = 32;
  localparam int unsigned BUYRUK_BIT           = 32;
  localparam logic [31:0] BASLANGIC_VARSAYILAN = 32'h4000_0000;

  localparam logic [6:0] OPK_JAL = 7'b1101111;
  localparam logic [6:0] OPK_DAL = 7'b1100011;

  typedef enum logic [1:0] {
    SIFIR = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2,
    IPTAL = 2'd3
  } durum_e;

endpackage

// File: rtl/getir_ongorucu.sv
// Static next-PC predictor: JAL target, backward B-type target, otherwise pc+4.
// Only built when GETIR_STATIK_TAHMIN_EN is defined.
`ifdef GETIR_STATIK_TAHMIN_EN
module getir_ongorucu
  import getir_birimi_pkg::*;
#(
  parameter int unsigned ADRES_BIT = ADRES_BIT_VARSAYILAN
) (
  input  logic [BUYRUK_BIT-1:0] buyruk_i,
  input  logic [ADRES_BIT-1:0]  pc_i,
  output logic [ADRES_BIT-1:0]  tahmin_pc_o
);

  logic [ADRES_BIT-1:0] j_imm;
  logic [ADRES_BIT-1:0] b_imm;

  assign j_imm = {{(ADRES_BIT-20){buyruk_i[31]}}, buyruk_i[19:12], buyruk_i[20],
                  buyruk_i[30:21], 1'b0};
  assign b_imm = {{(ADRES_BIT-12){buyruk_i[31]}}, buyruk_i[7], buyruk_i[30:25],
                  buyruk_i[11:8], 1'b0};

  // Forward branches are predicted not-taken (sign bit clear).
  always_comb begin
    tahmin_pc_o = pc_i + ADRES_BIT'(4);
    if (buyruk_i[6:0] == OPK_JAL) begin
      tahmin_pc_o = pc_i + j_imm;
    end else if (buyruk_i[6:0] == OPK_DAL && buyruk_i[31]) begin
      tahmin_pc_o = pc_i + b_imm;
    end
  end

endmodule
`endif

// File: rtl/getir_birimi.sv
// GETIR instruction fetch stage: PC owner, single-outstanding L1I requester, skid-buffered COZ output.
// Static branch prediction enabled by defining GETIR_STATIK_TAHMIN_EN (default: always pc+4).
module getir_birimi
  import getir_birimi_pkg::*;
#(
  parameter int unsigned          ADRES_BIT        = ADRES_BIT_VARSAYILAN,
  parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRESI = ADRES_BIT'(BASLANGIC_VARSAYILAN)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ddb_durdur_i,
  input  logic                  ddb_bosalt_i,
  output logic                  ddb_hazir_o,
  output logic                  ddb_yanlis_tahmin_o,
  output logic [ADRES_BIT-1:0]  l1b_adres_o,
  output logic                  l1b_istek_gecerli_o,
  input  logic                  l1b_istek_hazir_i,
  input  logic [BUYRUK_BIT-1:0] l1b_buyruk_i,
  input  logic                  l1b_buyruk_gecerli_i,
  input  logic                  yrt_gecerli_i,
  input  logic [ADRES_BIT-1:0]  yrt_dogru_sonraki_pc_i,
  input  logic [ADRES_BIT-1:0]  yrt_tahmin_sonraki_pc_i,
  output logic [BUYRUK_BIT-1:0] coz_buyruk_o,
  output logic [ADRES_BIT-1:0]  coz_pc_o,
  output logic [ADRES_BIT-1:0]  coz_tahmin_pc_o,
  output logic                  coz_gecerli_o
);

  durum_e                durum_q, durum_d;
  logic [ADRES_BIT-1:0]  pc_q, pc_d;
  logic [ADRES_BIT-1:0]  adres_q, adres_d;
  logic                  istek_q, istek_d;

  logic [BUYRUK_BIT-1:0] coz_buyruk_q, coz_buyruk_d;
  logic [ADRES_BIT-1:0]  coz_pc_q, coz_pc_d;
  logic [ADRES_BIT-1:0]  coz_tahmin_q, coz_tahmin_d;
  logic                  coz_gecerli_q, coz_gecerli_d;

  logic [BUYRUK_BIT-1:0] skid_buyruk_q, skid_buyruk_d;
  logic [ADRES_BIT-1:0]  skid_pc_q, skid_pc_d;
  logic [ADRES_BIT-1:0]  skid_tahmin_q, skid_tahmin_d;
  logic                  skid_gecerli_q, skid_gecerli_d;

  logic                  yanlis;
  logic                  kabul;
  logic                  yanit_al;
  logic [ADRES_BIT-1:0]  tahmin_pc;

`ifdef GETIR_STATIK_TAHMIN_EN
  getir_ongorucu #(
    .ADRES_BIT (ADRES_BIT)
  ) u_ongorucu (
    .buyruk_i    (l1b_buyruk_i),
    .pc_i        (pc_q),
    .tahmin_pc_o (tahmin_pc)
  );
`else
  assign tahmin_pc = pc_q + ADRES_BIT'(4);
`endif

  assign yanlis   = yrt_gecerli_i && (yrt_dogru_sonraki_pc_i != yrt_tahmin_sonraki_pc_i);
  assign kabul    = istek_q && l1b_istek_hazir_i;
  assign yanit_al = (durum_q == BEKLE) && l1b_buyruk_gecerli_i && !yanlis;

  // Next-state: FSM, PC, output register and skid entry.
  always_comb begin
    durum_d        = durum_q;
    pc_d           = pc_q;
    coz_buyruk_d   = coz_buyruk_q;
    coz_pc_d       = coz_pc_q;
    coz_tahmin_d   = coz_tahmin_q;
    coz_gecerli_d  = coz_gecerli_q;
    skid_buyruk_d  = skid_buyruk_q;
    skid_pc_d      = skid_pc_q;
    skid_tahmin_d  = skid_tahmin_q;
    skid_gecerli_d = skid_gecerli_q;

    case (durum_q)
      SIFIR: durum_d = ISTEK;
      ISTEK: if (kabul) durum_d = yanlis ? IPTAL : BEKLE;
      BEKLE: begin
        if (l1b_buyruk_gecerli_i) begin
          durum_d = ISTEK;
          pc_d    = tahmin_pc;
        end else if (yanlis) begin
          durum_d = IPTAL;
        end
      end
      IPTAL: if (l1b_buyruk_gecerli_i) durum_d = ISTEK;
      default: durum_d = SIFIR;
    endcase

    if (yanlis) pc_d = yrt_dogru_sonraki_pc_i;

    if (yanlis) begin
      coz_gecerli_d  = 1'b0;
      skid_gecerli_d = 1'b0;
    end else begin
      if (ddb_bosalt_i) begin
        coz_gecerli_d  = 1'b0;
        skid_gecerli_d = 1'b0;
      end
      if (!ddb_durdur_i) begin
        // Skid drains first; it can never coexist with a live response.
        if (skid_gecerli_q && !ddb_bosalt_i) begin
          coz_buyruk_d   = skid_buyruk_q;
          coz_pc_d       = skid_pc_q;
          coz_tahmin_d   = skid_tahmin_q;
          coz_gecerli_d  = 1'b1;
          skid_gecerli_d = 1'b0;
        end else if (yanit_al) begin
          coz_buyruk_d  = l1b_buyruk_i;
          coz_pc_d      = pc_q;
          coz_tahmin_d  = tahmin_pc;
          coz_gecerli_d = 1'b1;
        end else begin
          coz_gecerli_d = 1'b0;
        end
      end else if (yanit_al) begin
        skid_buyruk_d  = l1b_buyruk_i;
        skid_pc_d      = pc_q;
        skid_tahmin_d  = tahmin_pc;
        skid_gecerli_d = 1'b1;
      end
    end

    istek_d = (durum_d == ISTEK) && !skid_gecerli_d;
    adres_d = pc_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q        <= SIFIR;
      pc_q           <= BASLANGIC_ADRESI;
      adres_q        <= '0;
      istek_q        <= 1'b0;
      coz_buyruk_q   <= '0;
      coz_pc_q       <= '0;
      coz_tahmin_q   <= '0;
      coz_gecerli_q  <= 1'b0;
      skid_buyruk_q  <= '0;
      skid_pc_q      <= '0;
      skid_tahmin_q  <= '0;
      skid_gecerli_q <= 1'b0;
    end else begin
      durum_q        <= durum_d;
      pc_q           <= pc_d;
      adres_q        <= adres_d;
      istek_q        <= istek_d;
      coz_buyruk_q   <= coz_buyruk_d;
      coz_pc_q       <= coz_pc_d;
      coz_tahmin_q   <= coz_tahmin_d;
      coz_gecerli_q  <= coz_gecerli_d;
      skid_buyruk_q  <= skid_buyruk_d;
      skid_pc_q      <= skid_pc_d;
      skid_tahmin_q  <= skid_tahmin_d;
      skid_gecerli_q <= skid_gecerli_d;
    end
  end

  assign ddb_hazir_o         = coz_gecerli_q | skid_gecerli_q;
  assign ddb_yanlis_tahmin_o = yanlis;
  assign l1b_adres_o         = adres_q;
  assign l1b_istek_gecerli_o = istek_q;
  assign coz_buyruk_o        = coz_buyruk_q;
  assign coz_pc_o            = coz_pc_q;
  assign coz_tahmin_pc_o     = coz_tahmin_q;
  assign coz_gecerli_o       = coz_gecerli_q;

endmodule

// File: tb/tb_getir_birimi.sv
// Scoreboard bench for getir_birimi with a simple L1I responder (1- or 2-cycle latency).
module tb_getir_birimi;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ddb_durdur_i, ddb_bosalt_i;
  logic        ddb_hazir_o, ddb_yanlis_tahmin_o;
  logic [31:0] l1b_adres_o;
  logic        l1b_istek_gecerli_o;
  logic        l1b_istek_hazir_i;
  logic [31:0] l1b_buyruk_i;
  logic        l1b_buyruk_gecerli_i;
  logic        yrt_gecerli_i;
  logic [31:0] yrt_dogru_sonraki_pc_i, yrt_tahmin_sonraki_pc_i;
  logic [31:0] coz_buyruk_o, coz_pc_o, coz_tahmin_pc_o;
  logic        coz_gecerli_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] buyruk;
    logic [31:0] tahmin;
  } beklenen_t;

  beklenen_t sb_q[$];
  int        teslim_cyc[$];
  int        errors = 0;
  int        checks = 0;
  int        teslim = 0;
  int        cyc = 0;
  int        gecikme = 1;
  bit        dal_bellek = 1'b0;

  getir_birimi dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .ddb_durdur_i            (ddb_durdur_i),
    .ddb_bosalt_i            (ddb_bosalt_i),
    .ddb_hazir_o             (ddb_hazir_o),
    .ddb_yanlis_tahmin_o     (ddb_yanlis_tahmin_o),
    .l1b_adres_o             (l1b_adres_o),
    .l1b_istek_gecerli_o     (l1b_istek_gecerli_o),
    .l1b_istek_hazir_i       (l1b_istek_hazir_i),
    .l1b_buyruk_i            (l1b_buyruk_i),
    .l1b_buyruk_gecerli_i    (l1b_buyruk_gecerli_i),
    .yrt_gecerli_i           (yrt_gecerli_i),
    .yrt_dogru_sonraki_pc_i  (yrt_dogru_sonraki_pc_i),
    .yrt_tahmin_sonraki_pc_i (yrt_tahmin_sonraki_pc_i),
    .coz_buyruk_o            (coz_buyruk_o),
    .coz_pc_o                (coz_pc_o),
    .coz_tahmin_pc_o         (coz_tahmin_pc_o),
    .coz_gecerli_o           (coz_gecerli_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (dal_bellek && a == 32'h4000_0020) return 32'hFE00_08E3;  // beq x0,x0,-16
    if (dal_bellek && a == 32'h4000_0010) return 32'h0400_006F;  // jal x0,+0x40
    return {a[24:0], 7'b0010011};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Instruction cache responder: one response per accepted request.
  initial begin
    logic        kab;
    logic [31:0] adr;
    logic        s1_v;
    logic [31:0] s1_d;
    s1_v = 1'b0;
    s1_d = '0;
    l1b_buyruk_gecerli_i = 1'b0;
    l1b_buyruk_i = '0;
    forever begin
      @(posedge clk);
      kab = l1b_istek_gecerli_o && l1b_istek_hazir_i;
      adr = l1b_adres_o;
      if (gecikme == 1) begin
        l1b_buyruk_gecerli_i <= kab;
        l1b_buyruk_i         <= mem(adr);
      end else begin
        l1b_buyruk_gecerli_i <= s1_v;
        l1b_buyruk_i         <= s1_d;
      end
      s1_v <= kab;
      s1_d <= mem(adr);
    end
  end

  // Scoreboard: each instruction consumed by COZ is popped and compared.
  initial begin
    beklenen_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && coz_gecerli_o && !ddb_durdur_i && !ddb_bosalt_i && !ddb_yanlis_tahmin_o) begin
        checks++;
        teslim++;
        teslim_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got pc=%h buyruk=%h tahmin=%h, none expected",
                   coz_pc_o, coz_buyruk_o, coz_tahmin_pc_o);
        end else begin
          e = sb_q.pop_front();
          if ({coz_pc_o, coz_buyruk_o, coz_tahmin_pc_o} !== e) begin
            errors++;
            $display("FAIL scoreboard_data: got pc=%h buyruk=%h tahmin=%h, want pc=%h buyruk=%h tahmin=%h",
                     coz_pc_o, coz_buyruk_o, coz_tahmin_pc_o, e.pc, e.buyruk, e.tahmin);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic adim(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ekle(input logic [31:0] pc, input logic [31:0] tahmin);
    beklenen_t e;
    e.pc = pc;
    e.buyruk = mem(pc);
    e.tahmin = tahmin;
    sb_q.push_back(e);
  endtask

  task automatic sifirla();
    rst_i = 1'b1;
    ddb_durdur_i = 1'b0;
    ddb_bosalt_i = 1'b0;
    l1b_istek_hazir_i = 1'b0;
    yrt_gecerli_i = 1'b0;
    yrt_dogru_sonraki_pc_i = '0;
    yrt_tahmin_sonraki_pc_i = '0;
    adim(2);
    sb_q.delete();
    teslim_cyc.delete();
    teslim = 0;
    rst_i = 1'b0;
  endtask

  task automatic yonlendir(input logic [31:0] hedef);
    yrt_gecerli_i = 1'b1;
    yrt_dogru_sonraki_pc_i = hedef;
    yrt_tahmin_sonraki_pc_i = 32'h4000_0004;
    adim(1);
    yrt_gecerli_i = 1'b0;
  endtask

  task automatic test_reset();
    gecikme = 1;
    rst_i = 1'b1;
    ddb_durdur_i = 1'b0;
    ddb_bosalt_i = 1'b0;
    l1b_istek_hazir_i = 1'b0;
    yrt_gecerli_i = 1'b0;
    yrt_dogru_sonraki_pc_i = '0;
    yrt_tahmin_sonraki_pc_i = '0;
    adim(3);
    checks++; if (coz_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_coz_gecerli: got %b want 0", coz_gecerli_o); end
    checks++; if (l1b_istek_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_istek: got %b want 0", l1b_istek_gecerli_o); end
    checks++; if (l1b_adres_o !== 32'h0) begin errors++; $display("FAIL reset_adres: got %h want 0", l1b_adres_o); end
    checks++; if (ddb_hazir_o !== 1'b0) begin errors++; $display("FAIL reset_hazir: got %b want 0", ddb_hazir_o); end
    checks++; if (coz_pc_o !== 32'h0) begin errors++; $display("FAIL reset_coz_pc: got %h want 0", coz_pc_o); end
  endtask

  task automatic test_sirali();
    gecikme = 1;
    sifirla();
    l1b_istek_hazir_i = 1'b1;
    for (int i = 0; i < 10; i++) ekle(32'h4000_0000 + 32'(4 * i), 32'h4000_0004 + 32'(4 * i));
    adim(1);
    checks++; if (l1b_istek_gecerli_o !== 1'b1 || l1b_adres_o !== 32'h4000_0000)
      begin errors++; $display("FAIL sirali_ilk_istek: got v=%b a=%h want v=1 a=40000000", l1b_istek_gecerli_o, l1b_adres_o); end
    adim(11);
    checks++; if (teslim !== 5) begin errors++; $display("FAIL sirali_adet: got %0d want 5", teslim); end
    for (int i = 1; i < 5 && i < teslim_cyc.size(); i++) begin
      checks++;
      if (teslim_cyc[i] - teslim_cyc[i-1] !== 2) begin
        errors++; $display("FAIL sirali_aralik: got %0d cycles want 2", teslim_cyc[i] - teslim_cyc[i-1]);
      end
    end
  endtask

  task automatic test_durdur();
    gecikme = 1;
    sifirla();
    l1b_istek_hazir_i = 1'b1;
    for (int i = 0; i < 8; i++) ekle(32'h4000_0000 + 32'(4 * i), 32'h4000_0004 + 32'(4 * i));
    adim(1);
    adim(2);
    ddb_durdur_i = 1'b1;
    adim(3);
    checks++; if (l1b_istek_gecerli_o !== 1'b0) begin errors++; $display("FAIL durdur_istek_yok: got %b want 0", l1b_istek_gecerli_o); end
    checks++; if (ddb_hazir_o !== 1'b1) begin errors++; $display("FAIL durdur_hazir: got %b want 1", ddb_hazir_o); end
    checks++; if (coz_gecerli_o !== 1'b1 || coz_pc_o !== 32'h4000_0000)
      begin errors++; $display("FAIL durdur_tutma: got v=%b pc=%h want v=1 pc=40000000", coz_gecerli_o, coz_pc_o); end
    adim(2);
    checks++; if (l1b_istek_gecerli_o !== 1'b0) begin errors++; $display("FAIL durdur_istek_yok2: got %b want 0", l1b_istek_gecerli_o); end
    ddb_durdur_i = 1'b0;
    adim(8);
    checks++; if (teslim !== 5) begin errors++; $display("FAIL durdur_adet: got %0d want 5", teslim); end
  endtask

  task automatic test_bosalt();
    gecikme = 1;
    sifirla();
    l1b_istek_hazir_i = 1'b1;
    ekle(32'h4000_0004, 32'h4000_0008);
    ekle(32'h4000_0008, 32'h4000_000C);
    ekle(32'h4000_000C, 32'h4000_0010);
    adim(3);
    ddb_durdur_i = 1'b1;
    ddb_bosalt_i = 1'b1;
    adim(1);
    checks++; if (coz_gecerli_o !== 1'b0) begin errors++; $display("FAIL bosalt_gecersiz: got %b want 0", coz_gecerli_o); end
    ddb_durdur_i = 1'b0;
    ddb_bosalt_i = 1'b0;
    adim(4);
    checks++; if (teslim !== 2) begin errors++; $display("FAIL bosalt_adet: got %0d want 2", teslim); end
  endtask

  task automatic test_yanlis_tahmin();
    gecikme = 2;
    sifirla();
    l1b_istek_hazir_i = 1'b1;
    for (int i = 0; i < 3; i++) ekle(32'h4000_0100 + 32'(4 * i), 32'h4000_0104 + 32'(4 * i));
    adim(2);
    yrt_gecerli_i = 1'b1;
    yrt_tahmin_sonraki_pc_i = 32'h4000_0010;
    yrt_dogru_sonraki_pc_i = 32'h4000_0010;
    #1;
    checks++; if (ddb_yanlis_tahmin_o !== 1'b0) begin errors++; $display("FAIL tahmin_dogru: got %b want 0", ddb_yanlis_tahmin_o); end
    yrt_dogru_sonraki_pc_i = 32'h4000_0100;
    #1;
    checks++; if (ddb_yanlis_tahmin_o !== 1'b1) begin errors++; $display("FAIL tahmin_yanlis: got %b want 1", ddb_yanlis_tahmin_o); end
    adim(1);
    yrt_gecerli_i = 1'b0;
    checks++; if (l1b_istek_gecerli_o !== 1'b0) begin errors++; $display("FAIL iptal_istek_yok: got %b want 0", l1b_istek_gecerli_o); end
    adim(1);
    checks++; if (l1b_istek_gecerli_o !== 1'b1 || l1b_adres_o !== 32'h4000_0100)
      begin errors++; $display("FAIL iptal_sonra_istek: got v=%b a=%h want v=1 a=40000100", l1b_istek_gecerli_o, l1b_adres_o); end
    adim(8);
    checks++; if (teslim !== 2) begin errors++; $display("FAIL yanlis_adet: got %0d want 2", teslim); end
  endtask

  task automatic test_istek_bekletme();
    gecikme = 1;
    sifirla();
    for (int i = 0; i < 3; i++) ekle(32'h4000_0200 + 32'(4 * i), 32'h4000_0204 + 32'(4 * i));
    adim(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (l1b_istek_gecerli_o !== 1'b1 || l1b_adres_o !== 32'h4000_0000) begin
        errors++; $display("FAIL bekletme_adres_sabit: got v=%b a=%h want v=1 a=40000000", l1b_istek_gecerli_o, l1b_adres_o);
      end
      adim(1);
    end
    yonlendir(32'h4000_0200);
    checks++; if (l1b_istek_gecerli_o !== 1'b1 || l1b_adres_o !== 32'h4000_0200)
      begin errors++; $display("FAIL bekletme_hedef: got v=%b a=%h want v=1 a=40000200", l1b_istek_gecerli_o, l1b_adres_o); end
    l1b_istek_hazir_i = 1'b1;
    adim(7);
    checks++; if (teslim !== 3) begin errors++; $display("FAIL bekletme_adet: got %0d want 3", teslim); end
  endtask

  task automatic test_sarma();
    gecikme = 1;
    sifirla();
    adim(1);
    yonlendir(32'hFFFF_FFFC);
    l1b_istek_hazir_i = 1'b1;
    ekle(32'hFFFF_FFFC, 32'h0000_0000);
    ekle(32'h0000_0000, 32'h0000_0004);
    ekle(32'h0000_0004, 32'h0000_0008);
    adim(7);
    checks++; if (teslim !== 3) begin errors++; $display("FAIL sarma_adet: got %0d want 3", teslim); end
    sifirla();
    adim(1);
    yonlendir(32'h4000_0302);
    l1b_istek_hazir_i = 1'b1;
    ekle(32'h4000_0302, 32'h4000_0306);
    ekle(32'h4000_0306, 32'h4000_030A);
    adim(5);
    checks++; if (teslim !== 2) begin errors++; $display("FAIL hizasiz_adet: got %0d want 2", teslim); end
  endtask

  task automatic test_tahmin();
    gecikme = 1;
    dal_bellek = 1'b1;
    sifirla();
    adim(1);
    yonlendir(32'h4000_0020);
    l1b_istek_hazir_i = 1'b1;
`ifdef GETIR_STATIK_TAHMIN_EN
    ekle(32'h4000_0020, 32'h4000_0010);
    ekle(32'h4000_0010, 32'h4000_0050);
    ekle(32'h4000_0050, 32'h4000_0054);
`else
    ekle(32'h4000_0020, 32'h4000_0024);
    ekle(32'h4000_0024, 32'h4000_0028);
    ekle(32'h4000_0028, 32'h4000_002C);
`endif
    adim(7);
    checks++; if (teslim !== 3) begin errors++; $display("FAIL tahmin_adet: got %0d want 3", teslim); end
    dal_bellek = 1'b0;
  endtask

  task automatic test_reset_ortada();
    gecikme = 2;
    sifirla();
    l1b_istek_hazir_i = 1'b1;
    adim(2);
    rst_i = 1'b1;
    adim(1);
    checks++; if (l1b_istek_gecerli_o !== 1'b0 || coz_gecerli_o !== 1'b0 || ddb_hazir_o !== 1'b0)
      begin errors++; $display("FAIL ortada_reset: got istek=%b coz=%b hazir=%b want 0 0 0",
                               l1b_istek_gecerli_o, coz_gecerli_o, ddb_hazir_o); end
    sb_q.delete();
    teslim = 0;
    ekle(32'h4000_0000, 32'h4000_0004);
    ekle(32'h4000_0004, 32'h4000_0008);
    rst_i = 1'b0;
    adim(6);
    checks++; if (teslim !== 1) begin errors++; $display("FAIL ortada_reset_adet: got %0d want 1", teslim); end
  endtask

  initial begin
    test_reset();
    test_sirali();
    test_durdur();
    test_bosalt();
    test_yanlis_tahmin();
    test_istek_bekletme();
    test_sarma();
    test_tahmin();
    test_reset_ortada();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
